mu_writeback: RTL and testbench

- Consumer stage directly downstream of the motion-update pipeline.
- Takes the updated per-particle offset, velocity, element and cell-crossing offsets.
- Particles that stay in the home cell are compacted back into that cell's position/velocity cache, and the particle count is rewritten at address 0.
- Particles that cross a cell boundary are queued in a migration FIFO toward the inter-cell/inter-FPGA router.

---
 rtl/mu_writeback.sv | 221 ++++++++++++++++++++++
 tb/tb_mu_writeback.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_writeback.sv
// Write-back stage after motion update: kept particles go back to the home-cell cache,
// cell-crossing particles are queued in a first-word-fall-through migration FIFO.
module mu_writeback #(
  parameter int OFFSET_STRUCT_WIDTH = 81,
  parameter int FLOAT_STRUCT_WIDTH  = 96,
  parameter int ELEMENT_WIDTH       = 2,
  parameter int PARTICLE_ID_WIDTH   = 7,
  parameter int MU_ID_WIDTH         = 8,
  parameter int MIG_FIFO_DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic                           i_num_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0]   i_particle_num,
  input  logic                           i_data_valid,
  input  logic [OFFSET_STRUCT_WIDTH-1:0] i_offset,
  input  logic [FLOAT_STRUCT_WIDTH-1:0]  i_vel,
  input  logic [ELEMENT_WIDTH-1:0]       i_element,
  input  logic [MU_ID_WIDTH-1:0]         i_MU_id,
  input  logic [1:0]                     i_cell_x_offset,
  input  logic [1:0]                     i_cell_y_offset,
  input  logic [1:0]                     i_cell_z_offset,
  output logic                           o_wr_en,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_wr_addr,
  output logic [OFFSET_STRUCT_WIDTH-1:0] o_wr_offset,
  output logic [FLOAT_STRUCT_WIDTH-1:0]  o_wr_vel,
  output logic [ELEMENT_WIDTH-1:0]       o_wr_element,
  output logic                           o_mig_valid,
  input  logic                           i_mig_ready,
  output logic [OFFSET_STRUCT_WIDTH-1:0] o_mig_offset,
  output logic [FLOAT_STRUCT_WIDTH-1:0]  o_mig_vel,
  output logic [ELEMENT_WIDTH-1:0]       o_mig_element,
  output logic [MU_ID_WIDTH-1:0]         o_mig_MU_id,
  output logic [5:0]                     o_mig_dst,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_keep_cnt,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_mig_cnt,
  output logic [1:0]                     o_err
);

  localparam int AW = $clog2(MIG_FIFO_DEPTH);
  localparam int EW = MU_ID_WIDTH + 6 + ELEMENT_WIDTH + FLOAT_STRUCT_WIDTH + OFFSET_STRUCT_WIDTH;
  localparam logic [PARTICLE_ID_WIDTH-1:0] PID_ZERO = {PARTICLE_ID_WIDTH{1'b0}};
  localparam logic [PARTICLE_ID_WIDTH-1:0] PID_ONE  = {{(PARTICLE_ID_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]                  PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_NUM = 3'd1,
    COLLECT  = 3'd2,
    COMMIT   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic [MU_ID_WIDTH-1:0]         mu_id;
    logic [5:0]                     dst;
    logic [ELEMENT_WIDTH-1:0]       element;
    logic [FLOAT_STRUCT_WIDTH-1:0]  vel;
    logic [OFFSET_STRUCT_WIDTH-1:0] offset;
  } mig_entry_t;

  function automatic logic is_stay(input logic [5:0] code);
    return code == 6'b010101;
  endfunction

  function automatic logic is_bad(input logic [5:0] code);
    return (code[1:0] == 2'b11) || (code[3:2] == 2'b11) || (code[5:4] == 2'b11);
  endfunction

  state_t                       state_r;
  logic [PARTICLE_ID_WIDTH-1:0] num_r;
  logic [PARTICLE_ID_WIDTH-1:0] rx_cnt_r;
  logic [PARTICLE_ID_WIDTH-1:0] keep_cnt_r;
  logic [PARTICLE_ID_WIDTH-1:0] mig_cnt_r;
  logic [AW:0]                  wr_ptr_r;
  logic [AW:0]                  rd_ptr_r;
  mig_entry_t                   mem_r [MIG_FIFO_DEPTH];

  logic [5:0]  code_s;
  logic        take_s;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;
  mig_entry_t  head_s;

  // Particle classification and FIFO handshake decode
  always_comb begin
    code_s  = {i_cell_z_offset, i_cell_y_offset, i_cell_x_offset};
    take_s  = (state_r == COLLECT) && i_data_valid;
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s   = !empty_s && i_mig_ready;
    push_s  = take_s && !is_stay(code_s) && !is_bad(code_s) && (!full_s || pop_s);
    if (empty_s) begin
      head_s = {EW{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  assign o_mig_valid   = !empty_s;
  assign o_mig_offset  = head_s.offset;
  assign o_mig_vel     = head_s.vel;
  assign o_mig_element = head_s.element;
  assign o_mig_MU_id   = head_s.mu_id;
  assign o_mig_dst     = head_s.dst;

  // Migration FIFO storage (payload is gated by empty, so no reset needed here)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= '{mu_id: i_MU_id, dst: code_s, element: i_element,
                                   vel: i_vel, offset: i_offset};
    end
  end

  // Migration FIFO pointers; a reset discards everything still queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Pass sequencing, cache write port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      num_r        <= PID_ZERO;
      rx_cnt_r     <= PID_ZERO;
      keep_cnt_r   <= PID_ZERO;
      mig_cnt_r    <= PID_ZERO;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= PID_ZERO;
      o_wr_offset  <= {OFFSET_STRUCT_WIDTH{1'b0}};
      o_wr_vel     <= {FLOAT_STRUCT_WIDTH{1'b0}};
      o_wr_element <= {ELEMENT_WIDTH{1'b0}};
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_keep_cnt   <= PID_ZERO;
      o_mig_cnt    <= PID_ZERO;
      o_err        <= 2'b00;
    end else begin
      o_wr_en <= 1'b0;
      o_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r    <= WAIT_NUM;
            o_busy     <= 1'b1;
            rx_cnt_r   <= PID_ZERO;
            keep_cnt_r <= PID_ZERO;
            mig_cnt_r  <= PID_ZERO;
            o_keep_cnt <= PID_ZERO;
            o_mig_cnt  <= PID_ZERO;
            o_err      <= 2'b00;
          end
        end
        WAIT_NUM: begin
          if (i_num_valid) begin
            num_r   <= i_particle_num;
            state_r <= (i_particle_num == PID_ZERO) ? COMMIT : COLLECT;
          end
        end
        COLLECT: begin
          if (i_data_valid) begin
            rx_cnt_r <= rx_cnt_r + PID_ONE;
            if (is_bad(code_s)) begin
              o_err[0] <= 1'b1;
            end else if (is_stay(code_s)) begin
              o_wr_en      <= 1'b1;
              o_wr_addr    <= keep_cnt_r + PID_ONE;
              o_wr_offset  <= i_offset;
              o_wr_vel     <= i_vel;
              o_wr_element <= i_element;
              keep_cnt_r   <= keep_cnt_r + PID_ONE;
            end else if (push_s) begin
              mig_cnt_r <= mig_cnt_r + PID_ONE;
            end else begin
              o_err[1] <= 1'b1;
            end
            if (rx_cnt_r + PID_ONE == num_r) state_r <= COMMIT;
          end
        end
        COMMIT: begin
          // Address 0 of the cache holds the particle count of the cell
          o_wr_en      <= 1'b1;
          o_wr_addr    <= PID_ZERO;
          o_wr_offset  <= {{(OFFSET_STRUCT_WIDTH-PARTICLE_ID_WIDTH){1'b0}}, keep_cnt_r};
          o_wr_vel     <= {FLOAT_STRUCT_WIDTH{1'b0}};
          o_wr_element <= {ELEMENT_WIDTH{1'b0}};
          state_r      <= DRAIN;
        end
        DRAIN: begin
          if (empty_s) begin
            state_r    <= DONE;
            o_done     <= 1'b1;
            o_keep_cnt <= keep_cnt_r;
            o_mig_cnt  <= mig_cnt_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu_writeback.sv
// Directed bench for mu_writeback: inputs change 2 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mu_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_num_valid, i_data_valid, i_mig_ready;
  logic [6:0]   i_particle_num;
  logic [80:0]  i_offset;
  logic [95:0]  i_vel;
  logic [1:0]   i_element;
  logic [7:0]   i_MU_id;
  logic [1:0]   i_cell_x_offset, i_cell_y_offset, i_cell_z_offset;
  logic         o_wr_en, o_mig_valid, o_busy, o_done;
  logic [6:0]   o_wr_addr, o_keep_cnt, o_mig_cnt;
  logic [80:0]  o_wr_offset, o_mig_offset;
  logic [95:0]  o_wr_vel, o_mig_vel;
  logic [1:0]   o_wr_element, o_mig_element, o_err;
  logic [7:0]   o_mig_MU_id;
  logic [5:0]   o_mig_dst;

  int checks = 0;
  int errors = 0;

  logic [6:0]  wa_q [$];
  logic [15:0] wo_q [$];
  logic [5:0]  md_q [$];
  logic [7:0]  mm_q [$];

  mu_writeback dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_valid(i_num_valid),
    .i_particle_num(i_particle_num), .i_data_valid(i_data_valid), .i_offset(i_offset),
    .i_vel(i_vel), .i_element(i_element), .i_MU_id(i_MU_id),
    .i_cell_x_offset(i_cell_x_offset), .i_cell_y_offset(i_cell_y_offset),
    .i_cell_z_offset(i_cell_z_offset), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_offset(o_wr_offset), .o_wr_vel(o_wr_vel), .o_wr_element(o_wr_element),
    .o_mig_valid(o_mig_valid), .i_mig_ready(i_mig_ready), .o_mig_offset(o_mig_offset),
    .o_mig_vel(o_mig_vel), .o_mig_element(o_mig_element), .o_mig_MU_id(o_mig_MU_id),
    .o_mig_dst(o_mig_dst), .o_busy(o_busy), .o_done(o_done), .o_keep_cnt(o_keep_cnt),
    .o_mig_cnt(o_mig_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Log every cache write and every migration pop
  always @(negedge clk) begin
    if (o_wr_en) begin
      wa_q.push_back(o_wr_addr);
      wo_q.push_back(o_wr_offset[15:0]);
    end
    if (o_mig_valid && i_mig_ready) begin
      md_q.push_back(o_mig_dst);
      mm_q.push_back(o_mig_MU_id);
    end
  end

  function automatic logic [80:0] mk_off(input int k);
    return {65'h0, 8'hA0, 8'(k)};
  endfunction

  function automatic logic [95:0] mk_vel(input int k);
    return {88'h0, 8'(k)} ^ 96'hC000_0000_0000_0000_0000_0000;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wo_q.delete(); md_q.delete(); mm_q.delete();
  endtask

  task automatic begin_pass(input logic [6:0] n);
    clear_logs();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_num_valid = 1'b1;
    i_particle_num = n;
    step();
    i_num_valid = 1'b0;
  endtask

  task automatic send(input logic [5:0] code, input int k);
    i_data_valid    = 1'b1;
    i_cell_x_offset = code[1:0];
    i_cell_y_offset = code[3:2];
    i_cell_z_offset = code[5:4];
    i_offset        = mk_off(k);
    i_vel           = mk_vel(k);
    i_element       = 2'(k);
    i_MU_id         = 8'h30 + 8'(k);
    step();
    i_data_valid    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(seen), 128'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    rst = 1'b0; i_start = 1'b0; i_num_valid = 1'b0; i_particle_num = 7'd0;
    i_data_valid = 1'b0; i_offset = 81'd0; i_vel = 96'd0; i_element = 2'd0;
    i_MU_id = 8'd0; i_cell_x_offset = 2'b01; i_cell_y_offset = 2'b01;
    i_cell_z_offset = 2'b01; i_mig_ready = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_wr_en", 128'(o_wr_en), 128'(1'b0));
    chk("rst_busy", 128'(o_busy), 128'(1'b0));
    chk("rst_mig_valid", 128'(o_mig_valid), 128'(1'b0));
    chk("rst_counts", 128'({o_keep_cnt, o_mig_cnt, o_err, o_done}), 128'(0));
    chk("rst_mig_dst", 128'(o_mig_dst), 128'(6'd0));
    step();
    rst = 1'b1;
    step();

    // 1: four stay particles back to back
    begin_pass(7'd4);
    chk("t1_busy", 128'(o_busy), 128'(1'b1));
    for (int k = 1; k <= 4; k++) begin
      send(6'b010101, k);
      @(negedge clk);
      chk("t1_wr_en", 128'(o_wr_en), 128'(1'b1));
      chk("t1_wr_addr", 128'(o_wr_addr), 128'(k));
      chk("t1_wr_offset", 128'(o_wr_offset), 128'(mk_off(k)));
      chk("t1_wr_vel", 128'(o_wr_vel), 128'(mk_vel(k)));
      chk("t1_wr_element", 128'(o_wr_element), 128'(k % 4));
    end
    @(negedge clk);
    chk("t1_cnt_wr", 128'({o_wr_en, o_wr_addr}), 128'({1'b1, 7'd0}));
    chk("t1_cnt_offset", 128'(o_wr_offset), 128'(4));
    chk("t1_cnt_vel_el", 128'({o_wr_vel, o_wr_element}), 128'(0));
    wait_done(20);
    chk("t1_keep", 128'(o_keep_cnt), 128'(4));
    chk("t1_mig", 128'(o_mig_cnt), 128'(0));
    chk("t1_err", 128'(o_err), 128'(2'b00));
    @(negedge clk);
    chk("t1_idle", 128'({o_busy, o_done}), 128'(2'b00));
    step();

    // 2: particles 2 and 4 cross in +x, downstream always ready
    i_mig_ready = 1'b1;
    begin_pass(7'd5);
    for (int k = 1; k <= 5; k++) send((k % 2 == 0) ? 6'b010110 : 6'b010101, k);
    wait_done(30);
    chk("t2_keep", 128'(o_keep_cnt), 128'(3));
    chk("t2_mig", 128'(o_mig_cnt), 128'(2));
    chk("t2_fifo_empty", 128'(o_mig_valid), 128'(1'b0));
    chk("t2_nwr", 128'(wa_q.size()), 128'(4));
    if (wa_q.size() == 4) begin
      chk("t2_addrs", 128'({wa_q[0], wa_q[1], wa_q[2], wa_q[3]}), 128'({7'd1, 7'd2, 7'd3, 7'd0}));
      chk("t2_offs", 128'({wo_q[0], wo_q[1], wo_q[2], wo_q[3]}),
          128'({16'hA001, 16'hA003, 16'hA005, 16'h0003}));
    end
    chk("t2_npop", 128'(md_q.size()), 128'(2));
    if (md_q.size() == 2) begin
      chk("t2_dst", 128'({md_q[0], md_q[1]}), 128'({6'b010110, 6'b010110}));
      chk("t2_mu", 128'({mm_q[0], mm_q[1]}), 128'({8'h32, 8'h34}));
    end
    step();

    // 3: twenty migrants with downstream stalled, then released
    i_mig_ready = 1'b0;
    begin_pass(7'd20);
    for (int k = 1; k <= 20; k++) send(6'b010110, k);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    chk("t3_no_done", 128'(dn), 128'(0));
    chk("t3_err", 128'(o_err), 128'(2'b10));
    chk("t3_valid", 128'(o_mig_valid), 128'(1'b1));
    step();
    i_mig_ready = 1'b1;
    wait_done(60);
    chk("t3_mig", 128'(o_mig_cnt), 128'(16));
    chk("t3_keep", 128'(o_keep_cnt), 128'(0));
    chk("t3_npop", 128'(md_q.size()), 128'(16));
    if (mm_q.size() == 16) begin
      chk("t3_order", 128'({mm_q[0], mm_q[15]}), 128'({8'h31, 8'h40}));
    end
    chk("t3_wr", 128'(wa_q.size()), 128'(1));
    step();

    // 4: empty pass
    begin_pass(7'd0);
    wait_done(20);
    chk("t4_nwr", 128'(wa_q.size()), 128'(1));
    if (wa_q.size() == 1) chk("t4_wr", 128'({wa_q[0], wo_q[0]}), 128'({7'd0, 16'h0000}));
    chk("t4_counts", 128'({o_keep_cnt, o_mig_cnt, o_err}), 128'(0));
    step();

    // 5: illegal y code on the middle particle
    begin_pass(7'd3);
    send(6'b010101, 1);
    send(6'b011101, 2);
    send(6'b010101, 3);
    wait_done(20);
    chk("t5_err", 128'(o_err), 128'(2'b01));
    chk("t5_keep", 128'(o_keep_cnt), 128'(2));
    chk("t5_nwr", 128'(wa_q.size()), 128'(3));
    if (wa_q.size() == 3) begin
      chk("t5_addrs", 128'({wa_q[0], wa_q[1], wa_q[2]}), 128'({7'd1, 7'd2, 7'd0}));
      chk("t5_offs", 128'({wo_q[0], wo_q[1], wo_q[2]}), 128'({16'hA001, 16'hA003, 16'h0002}));
    end
    step();

    // 6: reset in the middle of COLLECT with a migrant queued
    i_mig_ready = 1'b0;
    begin_pass(7'd5);
    send(6'b010101, 1);
    send(6'b010110, 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_out", 128'({o_wr_en, o_busy, o_mig_valid, o_done, o_err, o_wr_addr}), 128'(0));
    step();
    rst = 1'b1;
    clear_logs();
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    chk("t6_quiet", 128'({dn[7:0], 8'(wa_q.size()), o_busy}), 128'(0));
    step();
    begin_pass(7'd2);
    send(6'b010101, 1);
    send(6'b010101, 2);
    wait_done(20);
    chk("t6_counts", 128'({o_keep_cnt, o_mig_cnt, o_err}), 128'({7'd2, 7'd0, 2'b00}));
    chk("t6_nwr", 128'(wa_q.size()), 128'(3));
    if (wa_q.size() == 3) begin
      chk("t6_addrs", 128'({wa_q[0], wa_q[1], wa_q[2]}), 128'({7'd1, 7'd2, 7'd0}));
      chk("t6_cnt_off", 128'(wo_q[2]), 128'(16'h0002));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
